// File: rtl/rtc_field_ctrl.sv
// Date/time field write sequencer: arbitrates RTC refresh writes against button-driven BCD editing.
// Latency: every write enable and wr_data appear one cycle after the triggering input; all outputs registered.
// Backpressure: none on reads/buttons; write-back holds rtc_wr_req until rtc_wr_ack.
module rtc_field_ctrl #(
  parameter int unsigned EDIT_TIMEOUT = 1_000_000_000,
  parameter int unsigned TO_W         = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       rd_valid,
  input  logic [2:0] rd_sel,
  input  logic [7:0] rd_data,
  input  logic [7:0] cur_val,
  input  logic       rtc_wr_ack,
  output logic [7:0] wr_data,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       en_day,
  output logic       en_mon,
  output logic       en_ano,
  output logic       edit_mode,
  output logic [2:0] edit_field,
  output logic       rtc_wr_req
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EDIT_LOAD = 2'd1,
    S_EDIT      = 2'd2,
    S_COMMIT    = 2'd3
  } state_t;

  localparam logic [2:0]      LAST_FIELD = 3'd5;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(EDIT_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [2:0]      field_q, field_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [5:0]      en_q, en_d;
  logic [7:0]      wd_q, wd_d;
  logic            em_q, em_d;
  logic            req_q, req_d;
  logic            btn_any;

  // Smallest legal BCD value of a field (day and month start at 01).
  function automatic logic [7:0] fld_min(input logic [2:0] f);
    fld_min = (f == 3'd3 || f == 3'd4) ? 8'h01 : 8'h00;
  endfunction

  // Largest legal BCD value of a field.
  function automatic logic [7:0] fld_max(input logic [2:0] f);
    case (f)
      3'd0, 3'd1: fld_max = 8'h59;
      3'd2:       fld_max = 8'h23;
      3'd3:       fld_max = 8'h31;
      3'd4:       fld_max = 8'h12;
      default:    fld_max = 8'h99;
    endcase
  endfunction

  // Both nibbles decimal and value inside the field's range; for valid BCD
  // a plain binary compare orders values the same as their decimal meaning.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [2:0] f);
    bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
             (v >= fld_min(f)) && (v <= fld_max(f));
  endfunction

  // BCD +1 with wrap from max to min.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [2:0] f);
    if (v >= fld_max(f))       bcd_inc = fld_min(f);
    else if (v[3:0] == 4'd9)   bcd_inc = {v[7:4] + 4'd1, 4'h0};
    else                       bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD -1 with wrap from min to max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [2:0] f);
    if (v <= fld_min(f))       bcd_dec = fld_max(f);
    else if (v[3:0] == 4'd0)   bcd_dec = {v[7:4] - 4'd1, 4'h9};
    else                       bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign btn_any = btn_edit | btn_next | btn_up | btn_down;

  // Next-state, shadow arithmetic and registered-output values.
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    shadow_d = shadow_q;
    to_d     = to_q;
    en_d     = '0;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        to_d = '0;
        // A read arriving with btn_edit is still written before editing starts.
        if (rd_valid && rd_sel <= LAST_FIELD) begin
          en_d = 6'b000001 << rd_sel;
          wd_d = rd_data;
        end
        if (btn_edit) begin
          state_d = S_EDIT_LOAD;
          field_d = 3'd0;
        end
      end
      S_EDIT_LOAD: begin
        // Garbage in the register bank is replaced by the field minimum.
        shadow_d = bcd_ok(cur_val, field_q) ? cur_val : fld_min(field_q);
        to_d     = '0;
        state_d  = S_EDIT;
      end
      S_EDIT: begin
        if (btn_any)             to_d = '0;
        else if (to_q == TO_LAST) begin
          to_d    = '0;
          state_d = S_COMMIT;
        end else                 to_d = to_q + 1'b1;
        if (btn_edit) begin
          state_d = S_COMMIT;
        end else if (btn_next) begin
          field_d = (field_q == LAST_FIELD) ? 3'd0 : field_q + 3'd1;
          state_d = S_EDIT_LOAD;
        end else if (btn_up ^ btn_down) begin
          shadow_d = btn_up ? bcd_inc(shadow_q, field_q) : bcd_dec(shadow_q, field_q);
          en_d     = 6'b000001 << field_q;
          wd_d     = shadow_d;
        end
      end
      S_COMMIT: begin
        if (rtc_wr_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    em_d  = (state_d != S_IDLE);
    req_d = (state_d == S_COMMIT);
  end

  // State and output registers; reset discards any pending edit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      field_q  <= 3'd0;
      shadow_q <= 8'h00;
      to_q     <= '0;
      en_q     <= '0;
      wd_q     <= 8'h00;
      em_q     <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      shadow_q <= shadow_d;
      to_q     <= to_d;
      en_q     <= en_d;
      wd_q     <= wd_d;
      em_q     <= em_d;
      req_q    <= req_d;
    end
  end

  assign wr_data    = wd_q;
  assign en_sec     = en_q[0];
  assign en_min     = en_q[1];
  assign en_hour    = en_q[2];
  assign en_day     = en_q[3];
  assign en_mon     = en_q[4];
  assign en_ano     = en_q[5];
  assign edit_mode  = em_q;
  assign edit_field = field_q;
  assign rtc_wr_req = req_q;

endmodule

// File: tb/tb_rtc_field_ctrl.sv
// Testbench for rtc_field_ctrl: directed scenarios then random traffic, every cycle scored against a decimal model.
// Latency: model expects outputs one clock after inputs are sampled.
// Backpressure: bench drives rtc_wr_ack directly, randomly or by scenario.
module tb_rtc_field_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_edit, btn_next, btn_up, btn_down;
  logic       rd_valid;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic [7:0] cur_val;
  logic       rtc_wr_ack;
  logic [7:0] wr_data;
  logic       en_sec, en_min, en_hour, en_day, en_mon, en_ano;
  logic       edit_mode;
  logic [2:0] edit_field;
  logic       rtc_wr_req;

  always #5 clk = ~clk;

  rtc_field_ctrl #(.EDIT_TIMEOUT(TO), .TO_W(30)) dut (
    .clk(clk), .reset(reset),
    .btn_edit(btn_edit), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_data(rd_data),
    .cur_val(cur_val), .rtc_wr_ack(rtc_wr_ack),
    .wr_data(wr_data),
    .en_sec(en_sec), .en_min(en_min), .en_hour(en_hour),
    .en_day(en_day), .en_mon(en_mon), .en_ano(en_ano),
    .edit_mode(edit_mode), .edit_field(edit_field), .rtc_wr_req(rtc_wr_req)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 load, 2 edit, 3 commit; field values kept as decimal integers.
  int         m_mode = 0, m_field = 0, m_val = 0, m_idle = 0;
  logic [5:0] e_en = '0;
  logic [7:0] e_wd = '0;

  function automatic int dmin(input int f);
    return (f == 3 || f == 4) ? 1 : 0;
  endfunction

  function automatic int dmax(input int f);
    case (f)
      0, 1:    return 59;
      2:       return 23;
      3:       return 31;
      4:       return 12;
      default: return 99;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction

  task automatic model_step();
    int hi, lo, d;
    bit any;
    e_en = '0;
    if (reset) begin
      m_mode = 0; m_field = 0; m_val = 0; m_idle = 0; e_wd = 8'h00;
    end else begin
      case (m_mode)
        0: begin
          if (rd_valid && rd_sel < 3'd6) begin
            e_en = 6'(1) << rd_sel;
            e_wd = rd_data;
          end
          if (btn_edit) begin m_mode = 1; m_field = 0; end
        end
        1: begin
          hi = int'(cur_val[7:4]);
          lo = int'(cur_val[3:0]);
          d  = hi * 10 + lo;
          if (hi < 10 && lo < 10 && d >= dmin(m_field) && d <= dmax(m_field)) m_val = d;
          else m_val = dmin(m_field);
          m_mode = 2;
          m_idle = 0;
        end
        2: begin
          any = btn_edit || btn_next || btn_up || btn_down;
          if (btn_edit) m_mode = 3;
          else if (btn_next) begin
            m_field = (m_field + 1) % 6;
            m_mode  = 1;
          end else if (btn_up != btn_down) begin
            if (btn_up) m_val = (m_val == dmax(m_field)) ? dmin(m_field) : m_val + 1;
            else        m_val = (m_val == dmin(m_field)) ? dmax(m_field) : m_val - 1;
            e_en = 6'(1) << m_field;
            e_wd = to_bcd(m_val);
          end
          // m_idle is the number of button-free edit cycles already seen.
          if (any) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TO) m_mode = 3;
          end
        end
        default: begin
          if (rtc_wr_ack) m_mode = 0;
        end
      endcase
    end
  endtask

  // One clock: model consumes the sampled inputs, DUT outputs are scored 1 ns later, pulses cleared.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("en_vec", {26'd0, en_ano, en_mon, en_day, en_hour, en_min, en_sec}, {26'd0, e_en});
    if (e_en != 6'd0 || reset) chk("wr_data", {24'd0, wr_data}, {24'd0, e_wd});
    chk("edit_mode", {31'd0, edit_mode}, {31'd0, (m_mode != 0)});
    chk("edit_field", {29'd0, edit_field}, 32'(m_field));
    chk("wr_req", {31'd0, rtc_wr_req}, {31'd0, (m_mode == 3)});
    btn_edit = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    rd_valid = 0; rtc_wr_ack = 0;
  endtask

  initial begin
    int p;
    reset = 1; btn_edit = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    rd_valid = 0; rd_sel = 0; rd_data = 0; cur_val = 0; rtc_wr_ack = 0;
    cyc(); cyc();
    reset = 0;

    // RTC read of year in idle.
    rd_valid = 1; rd_sel = 3'd5; rd_data = 8'h16; cyc();
    chk("yr_en", {31'd0, en_ano}, 32'd1);
    chk("yr_data", {24'd0, wr_data}, 32'h16);

    // Hour edit wrapping both ways.
    cur_val = 8'h23;
    btn_edit = 1; cyc(); cyc();
    btn_next = 1; cyc(); cyc();
    btn_next = 1; cyc(); cyc();
    chk("field2", {29'd0, edit_field}, 32'd2);
    btn_up = 1; cyc();
    chk("hr_up_en", {31'd0, en_hour}, 32'd1);
    chk("hr_up", {24'd0, wr_data}, 32'h00);
    btn_down = 1; cyc();
    chk("hr_dn", {24'd0, wr_data}, 32'h23);

    // Day wraps down 01->31, month wraps up 12->01, seconds carry 09->10.
    cur_val = 8'h01; btn_next = 1; cyc(); cyc();
    btn_down = 1; cyc();
    chk("day_dn", {24'd0, wr_data}, 32'h31);
    cur_val = 8'h12; btn_next = 1; cyc(); cyc();
    btn_up = 1; cyc();
    chk("mon_up", {24'd0, wr_data}, 32'h01);
    btn_next = 1; cyc(); cyc();
    cur_val = 8'h09; btn_next = 1; cyc(); cyc();
    btn_up = 1; cyc();
    chk("sec_up", {24'd0, wr_data}, 32'h10);

    // Reads dropped during edit; simultaneous up/down is a no-op.
    rd_valid = 1; rd_sel = 3'd0; rd_data = 8'h55; cyc();
    chk("rd_drop", {31'd0, en_sec}, 32'd0);
    btn_up = 1; btn_down = 1; cyc();
    chk("updn_en", {26'd0, en_ano, en_mon, en_day, en_hour, en_min, en_sec}, 32'd0);
    btn_up = 1; cyc();
    chk("updn_keep", {24'd0, wr_data}, 32'h11);

    // Commit handshake.
    btn_edit = 1; cyc();
    chk("req_on", {31'd0, rtc_wr_req}, 32'd1);
    repeat (5) begin
      cyc();
      chk("req_hold", {31'd0, rtc_wr_req}, 32'd1);
    end
    rtc_wr_ack = 1; cyc();
    chk("req_drop", {31'd0, rtc_wr_req}, 32'd0);
    chk("em_drop", {31'd0, edit_mode}, 32'd0);

    // Edit timeout: one load cycle plus TO idle edit cycles, then commit; reset aborts it.
    btn_edit = 1; cyc();
    repeat (TO) cyc();
    chk("to_before", {31'd0, rtc_wr_req}, 32'd0);
    cyc();
    chk("to_commit", {31'd0, rtc_wr_req}, 32'd1);
    reset = 1; cyc();
    chk("rst_req", {31'd0, rtc_wr_req}, 32'd0);
    chk("rst_em", {31'd0, edit_mode}, 32'd0);
    reset = 0;

    // Random traffic; second half uses sparse buttons so timeouts occur.
    for (int i = 0; i < 4000; i++) begin
      p = (i < 2000) ? 6 : 40;
      reset      = ($urandom_range(0, 299) == 0);
      btn_edit   = ($urandom_range(0, p * 2) == 0);
      btn_next   = ($urandom_range(0, p) == 0);
      btn_up     = ($urandom_range(0, p) == 0);
      btn_down   = ($urandom_range(0, p) == 0);
      rd_valid   = ($urandom_range(0, 2) == 0);
      rd_sel     = 3'($urandom_range(0, 7));
      rd_data    = 8'($urandom);
      cur_val    = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 99)) : 8'($urandom);
      rtc_wr_ack = ($urandom_range(0, 3) == 0);
      cyc();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_field_ctrl.md
Name: rtc_field_ctrl

Overview:
- Sequences writes into the six date/time field registers: seconds, minutes, hours, day, month and year.
- Each field register is an 8-bit BCD register with its own EN input.
- Arbitrates between two writers:
  - the RTC read sequencer, which refreshes fields from the chip;
  - the user edit path, driven by buttons, which does BCD increment/decrement with per-field limits and then requests a write-back to the RTC.
- Sits between the RTC interface FSM, the debounced button block and the field register bank.

Parameters:
- EDIT_TIMEOUT, 1_000_000_000, idle cycles in edit mode before automatic commit (10 s at 100 MHz).
- TO_W, 30, width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_edit  in  1  single-cycle pulse (debounced upstream): enter edit / commit
- btn_next  in  1  single-cycle pulse: select next field
- btn_up  in  1  single-cycle pulse: increment selected field
- btn_down  in  1  single-cycle pulse: decrement selected field
- rd_valid  in  1  RTC read sequencer has a field value
- rd_sel  in  3  field code of rd_data
- rd_data  in  8  BCD value from RTC
- cur_val  in  8  current value of field edit_field (external mux)
- rtc_wr_ack  in  1  RTC interface accepted write-back
- wr_data  out  8  data bus to all field registers
- en_sec, en_min, en_hour, en_day, en_mon, en_ano  out  1 each  one-hot write enables
- edit_mode  out  1  high in EDIT_LOAD/EDIT/COMMIT
- edit_field  out  3  field currently selected
- rtc_wr_req  out  1  request to push register bank to RTC

Behaviour:
- Field codes: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year. Codes 6 and 7 are invalid: ignored on rd_sel, never produced on edit_field.
- BCD ranges:
  - sec/min 00–59
  - hour 00–23
  - day 01–31
  - month 01–12
  - year 00–99
- Reset values: all outputs 0, state IDLE, shadow 0, timeout counter 0.
- All outputs are registered. At most one en_* is high per cycle, for exactly one cycle.
- States:
  - IDLE:
    - rd_valid=1 with valid rd_sel at cycle n → en_<rd_sel>=1 and wr_data=rd_data at n+1.
    - btn_edit → EDIT_LOAD, edit_field=0.
    - rd_valid and btn_edit in the same cycle: the read write is still issued, then enter EDIT_LOAD.
  - EDIT_LOAD:
    - One cycle; capture cur_val into shadow, then → EDIT.
    - Invalid BCD or out-of-range cur_val → shadow = field minimum.
  - EDIT:
    - btn_up at n → shadow = shadow+1 (BCD); en_<field> and wr_data=new shadow at n+1.
    - Increment wraps from max to min (59→00, 23→00, 31→01, 12→01, 99→00).
    - btn_down mirrors btn_up, wrapping from min to max.
    - btn_up and btn_down in the same cycle: no change, no enable.
    - btn_next: edit_field = (field+1) wrapping 5→0, then → EDIT_LOAD. It has priority over up/down in the same cycle, which are ignored.
    - btn_edit (highest priority) → COMMIT.
    - rd_valid is ignored and dropped for the whole of edit mode, so no RTC overwrite of edited values.
    - Timeout counter clears on any button pulse and otherwise increments. Reaching EDIT_TIMEOUT-1 → COMMIT.
  - COMMIT:
    - rtc_wr_req=1 held until rtc_wr_ack=1.
    - On the ack cycle, rtc_wr_req drops the next cycle and state → IDLE.
    - Buttons are ignored.
- Reset mid-operation: any state → IDLE next edge; rtc_wr_req, en_* and edit_mode go to 0. A pending edit is discarded and not committed.
- BCD arithmetic: the low nibble carries/borrows at 9/0; the high nibble is adjusted accordingly, then the range check is applied.

Test Plan:
- Reset, then rd_valid=1, rd_sel=5, rd_data=8'h16 → one cycle later en_ano=1, wr_data=8'h16, all other enables 0.
- btn_edit; btn_next ×2 (field 2); cur_val=8'h23; btn_up → en_hour=1, wr_data=8'h00. Then btn_down → wr_data=8'h23.
- Field 3, cur_val=8'h01, btn_down → wr_data=8'h31. Field 4, cur_val=8'h12, btn_up → wr_data=8'h01. Field 0, cur_val=8'h09, btn_up → 8'h10.
- In EDIT, drive rd_valid=1, rd_sel=0 → no en_* asserted. btn_up and btn_down together → no enable, shadow unchanged.
- btn_edit in EDIT → rtc_wr_req=1 held while ack=0 for 5 cycles; ack pulse → req 0 next cycle, edit_mode 0.
- Timeout: set EDIT_TIMEOUT=16 and enter EDIT with no buttons → COMMIT entered after 16 cycles. Assert reset during COMMIT → rtc_wr_req=0, state IDLE.
